// File: rtl/io_store_rmw_aligner.sv
// io_store_rmw_aligner
//
// Sequential IO store aligner. It takes byte/word/double/quad stores at any
// byte address inside an IO port buffer and applies them to a single-ported
// element buffer. The buffer only accepts whole-element writes, so each touched
// element goes through read-modify-write. A store that straddles two adjacent
// elements does two RMW passes, and the second pass wraps from the last
// element back to element 0.
//
// Ports:
//   clk            clock
//   sync_rst       synchronous active-high reset
//   ReqValid       store request valid
//   ReqReady       request accepted when ReqValid and ReqReady are both high
//   MinorOpcodeIn  [1:0] size code (0 byte .. 3 quad), [3:2] ignored
//   DataAddrIn     byte address; only the port-buffer offset bits are used
//   DataIn         store data, least-significant byte first
//   RdValid        element read strobe
//   RdIndex        element read index
//   RdData         read data, valid the cycle after RdValid
//   WrValid        full-element write strobe
//   WrIndex        element write index
//   WrData         merged element data
//   Busy           high whenever the block is not idle
//   ErrorOut       one-cycle pulse when the store is wider than an element
module io_store_rmw_aligner #(
  parameter int DATABITWIDTH  = 16,
  parameter int PORTBYTEWIDTH = 16,
  localparam int ELEMENTBYTES = DATABITWIDTH / 8,
  localparam int BUFFERCOUNT  = ((PORTBYTEWIDTH * 8 / DATABITWIDTH) > 1) ?
                                (PORTBYTEWIDTH * 8 / DATABITWIDTH) : 1,
  localparam int BUFFERINDEXBITWIDTH = (BUFFERCOUNT > 1) ? $clog2(BUFFERCOUNT) : 1
) (
  input  logic                           clk,
  input  logic                           sync_rst,
  input  logic                           ReqValid,
  output logic                           ReqReady,
  input  logic [3:0]                     MinorOpcodeIn,
  input  logic [DATABITWIDTH-1:0]        DataAddrIn,
  input  logic [DATABITWIDTH-1:0]        DataIn,
  output logic                           RdValid,
  output logic [BUFFERINDEXBITWIDTH-1:0] RdIndex,
  input  logic [DATABITWIDTH-1:0]        RdData,
  output logic                           WrValid,
  output logic [BUFFERINDEXBITWIDTH-1:0] WrIndex,
  output logic [DATABITWIDTH-1:0]        WrData,
  output logic                           Busy,
  output logic                           ErrorOut
);

  localparam int ADDRBITS = (PORTBYTEWIDTH > 1) ? $clog2(PORTBYTEWIDTH) : 1;
  localparam int LANEBITS = (ELEMENTBYTES > 1) ? $clog2(ELEMENTBYTES) : 0;
  localparam logic [ADDRBITS-1:0] ADDRMASK = ADDRBITS'(PORTBYTEWIDTH - 1);
  localparam logic [ADDRBITS-1:0] LANEMASK = ADDRBITS'(ELEMENTBYTES - 1);

  typedef enum logic [2:0] {IDLE, RD0, MG0, WR0, RD1, MG1, WR1, ERR} stateT;

  stateT state;

  logic [ADDRBITS-1:0]            reqAddr;
  logic [3:0]                     reqSize;
  logic [BUFFERINDEXBITWIDTH-1:0] reqElem;
  logic [BUFFERINDEXBITWIDTH-1:0] reqNextElem;
  logic                           reqSpan;
  logic                           reqTooBig;

  logic [ADDRBITS-1:0]            storeLane;
  logic [3:0]                     storeSize;
  logic [DATABITWIDTH-1:0]        storeData;
  logic [BUFFERINDEXBITWIDTH-1:0] elem0;
  logic [BUFFERINDEXBITWIDTH-1:0] elem1;
  logic                           storeSpan;

  logic [DATABITWIDTH-1:0]        mergedData;
  logic                           unusedInputs;

  // Upper address bits and opcode bits [3:2] carry no meaning here.
  assign unusedInputs = ^{MinorOpcodeIn[3:2], DataAddrIn};

  assign ReqReady = (state == IDLE) && !sync_rst;

  // Decode the incoming request: port-relative byte address, size in bytes,
  // first element, the element after it (wrapping), and whether it spans.
  // With a single element the "next" element is element 0 again.
  assign reqAddr     = DataAddrIn[ADDRBITS-1:0] & ADDRMASK;
  assign reqSize     = 4'd1 << MinorOpcodeIn[1:0];
  assign reqElem     = BUFFERINDEXBITWIDTH'(reqAddr >> LANEBITS);
  assign reqNextElem = (BUFFERCOUNT == 1) ? '0 : reqElem + 1'b1;
  assign reqSpan     = (32'(reqAddr & LANEMASK) + 32'(reqSize)) > 32'(ELEMENTBYTES);
  assign reqTooBig   = 32'(reqSize) > 32'(ELEMENTBYTES);

  // Merge the store bytes into the element just read. For each lane, work out
  // which store byte (if any) lands there: in the first element store byte 0
  // sits at the start lane, in the second element the count continues from
  // where the first element ran out of lanes.
  always_comb begin
    int byteIdx;
    mergedData = RdData;
    byteIdx    = 0;
    for (int lane = 0; lane < ELEMENTBYTES; lane++) begin
      if (state == MG1) begin
        byteIdx = ELEMENTBYTES - int'(storeLane) + lane;
      end else begin
        byteIdx = lane - int'(storeLane);
      end
      if (byteIdx >= 0 && byteIdx < int'(storeSize)) begin
        mergedData[lane*8 +: 8] = storeData[byteIdx*8 +: 8];
      end
    end
  end

  // Control FSM. Outputs are registered alongside the state so that the
  // strobes are already valid in the state they belong to. A reset simply
  // abandons whatever RMW pass was in flight.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state    <= IDLE;
      RdValid  <= 1'b0;
      WrValid  <= 1'b0;
      ErrorOut <= 1'b0;
      Busy     <= 1'b0;
      RdIndex  <= '0;
      WrIndex  <= '0;
      WrData   <= '0;
    end else begin
      RdValid  <= 1'b0;
      WrValid  <= 1'b0;
      ErrorOut <= 1'b0;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            storeLane <= reqAddr & LANEMASK;
            storeSize <= reqSize;
            storeData <= DataIn;
            elem0     <= reqElem;
            elem1     <= reqNextElem;
            storeSpan <= reqSpan;
            Busy      <= 1'b1;
            if (reqTooBig) begin
              state    <= ERR;
              ErrorOut <= 1'b1;
            end else begin
              state   <= RD0;
              RdValid <= 1'b1;
              RdIndex <= reqElem;
            end
          end
        end
        RD0: state <= MG0;
        MG0: begin
          WrData  <= mergedData;
          state   <= WR0;
          WrValid <= 1'b1;
          WrIndex <= elem0;
        end
        WR0: begin
          if (storeSpan) begin
            state   <= RD1;
            RdValid <= 1'b1;
            RdIndex <= elem1;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        RD1: state <= MG1;
        MG1: begin
          WrData  <= mergedData;
          state   <= WR1;
          WrValid <= 1'b1;
          WrIndex <= elem1;
        end
        WR1, ERR: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_store_rmw_aligner.sv
// tb_io_store_rmw_aligner
//
// Bench for io_store_rmw_aligner with a 16-bit element, 16-byte port buffer
// (8 elements). The bench owns the element RAM, keeps a byte-level image of
// what the port buffer should contain, and derives every expected cycle of
// DUT activity from that image and the store rules.
module tb_io_store_rmw_aligner;

  localparam int PBW = 16;
  localparam int EB  = 2;
  localparam int BC  = 8;

  logic        clk;
  logic        sync_rst;
  logic        ReqValid;
  logic        ReqReady;
  logic [3:0]  MinorOpcodeIn;
  logic [15:0] DataAddrIn;
  logic [15:0] DataIn;
  logic        RdValid;
  logic [2:0]  RdIndex;
  logic [15:0] RdData;
  logic        WrValid;
  logic [2:0]  WrIndex;
  logic [15:0] WrData;
  logic        Busy;
  logic        ErrorOut;

  io_store_rmw_aligner #(
    .DATABITWIDTH (16),
    .PORTBYTEWIDTH(16)
  ) dut (
    .clk          (clk),
    .sync_rst     (sync_rst),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .MinorOpcodeIn(MinorOpcodeIn),
    .DataAddrIn   (DataAddrIn),
    .DataIn       (DataIn),
    .RdValid      (RdValid),
    .RdIndex      (RdIndex),
    .RdData       (RdData),
    .WrValid      (WrValid),
    .WrIndex      (WrIndex),
    .WrData       (WrData),
    .Busy         (Busy),
    .ErrorOut     (ErrorOut)
  );

  typedef struct {
    int cyc;
    bit rdValid;
    int rdIndex;
    bit wrValid;
    int wrIndex;
    int wrData;
    bit errorOut;
    bit busy;
    bit reqReady;
    bit fullCheck;
  } expRecT;

  expRecT      expQ[$];
  expRecT      cur;
  int          cycleNow = 0;
  int          compareCount = 0;
  int          failCount = 0;
  int          busyUntil = 0;
  int          lastAcc = 0;
  bit          checkEnable = 0;
  logic [7:0]  image[PBW];
  logic [7:0]  savedImage[PBW];
  logic [15:0] ram[BC];
  logic        pokeEn;
  logic [2:0]  pokeIdx;
  logic [15:0] pokeVal;
  int          busyCount = 0;
  int          strobeCount = 0;
  int          errCount = 0;
  int          acceptLog[$];

  // Free-running clock plus a cycle counter that names each clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNow <= cycleNow + 1;

  // Element RAM seen by the DUT: one-cycle read latency, full-element writes.
  // The bench can also poke values in directly while the DUT is idle.
  always @(posedge clk) begin
    if (pokeEn) begin
      ram[pokeIdx] <= pokeVal;
    end else if (WrValid) begin
      ram[WrIndex] <= WrData;
    end
    if (RdValid) begin
      RdData <= ram[RdIndex];
    end
  end

  // Hard time limit so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, compared=%0d", compareCount);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic expRecT blankRec(input int cyc);
    expRecT r;
    r.cyc       = cyc;
    r.rdValid   = 1'b0;
    r.rdIndex   = 0;
    r.wrValid   = 1'b0;
    r.wrIndex   = 0;
    r.wrData    = 0;
    r.errorOut  = 1'b0;
    r.busy      = 1'b0;
    r.reqReady  = 1'b0;
    r.fullCheck = 1'b0;
    return r;
  endfunction

  function automatic logic [15:0] modelElem(input int e);
    return {image[2*e+1], image[2*e]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s (cycle %0d): actual 0x%0h required 0x%0h",
               name, cycleNow, actual, expected);
    end
  endtask

  // Every cycle, compare the DUT against the expected record for that cycle,
  // or against plain idle behaviour when nothing is scheduled. Also keep a few
  // observation counters for the directed checks.
  always @(negedge clk) begin
    if (checkEnable) begin
      cur = blankRec(cycleNow);
      cur.reqReady = 1'b1;
      if (expQ.size() > 0 && expQ[0].cyc == cycleNow) begin
        cur = expQ.pop_front();
      end
      checkOutput("RdValid", RdValid, cur.rdValid);
      checkOutput("WrValid", WrValid, cur.wrValid);
      checkOutput("ErrorOut", ErrorOut, cur.errorOut);
      checkOutput("Busy", Busy, cur.busy);
      checkOutput("ReqReady", ReqReady, cur.reqReady);
      if (cur.rdValid || cur.fullCheck) begin
        checkOutput("RdIndex", RdIndex, cur.rdIndex);
      end
      if (cur.wrValid || cur.fullCheck) begin
        checkOutput("WrIndex", WrIndex, cur.wrIndex);
        checkOutput("WrData", WrData, cur.wrData);
      end
      busyCount   += int'(Busy === 1'b1);
      strobeCount += int'((RdValid === 1'b1) || (WrValid === 1'b1));
      errCount    += int'(ErrorOut === 1'b1);
      if (ReqValid === 1'b1 && ReqReady === 1'b1) begin
        acceptLog.push_back(cycleNow);
      end
    end
  end

  // Wait for the model to go idle with no request presented.
  task automatic waitIdle();
    ReqValid = 1'b0;
    while (cycleNow <= busyUntil) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setElement(input int e, input logic [15:0] v);
    waitIdle();
    pokeEn  = 1'b1;
    pokeIdx = 3'(e);
    pokeVal = v;
    image[2*e]   = v[7:0];
    image[2*e+1] = v[15:8];
    @(posedge clk);
    #1;
    pokeEn = 1'b0;
  endtask

  task automatic restoreElement(input int e);
    image[2*e]   = savedImage[2*e];
    image[2*e+1] = savedImage[2*e+1];
  endtask

  // Present one store. While the model says the DUT is busy, junk requests are
  // waved at it, which it must ignore. The model then places each store byte
  // in the byte image and schedules the expected read/merge/write cycles.
  task automatic applyStimulus(input logic [15:0] addr, input logic [3:0] opcode,
                               input logic [15:0] data);
    int n;
    int a;
    int e0;
    int e1;
    int acc;
    bit span;
    expRecT r;
    while (cycleNow <= busyUntil) begin
      ReqValid      = 1'($urandom_range(0, 1));
      MinorOpcodeIn = 4'($urandom);
      DataAddrIn    = 16'($urandom);
      DataIn        = 16'($urandom);
      @(posedge clk);
      #1;
    end
    savedImage    = image;
    acc           = cycleNow;
    lastAcc       = acc;
    ReqValid      = 1'b1;
    MinorOpcodeIn = opcode;
    DataAddrIn    = addr;
    DataIn        = data;
    n = 1 << opcode[1:0];
    a = int'(addr) % PBW;
    if (n > EB) begin
      r = blankRec(acc + 1);
      r.errorOut = 1'b1;
      r.busy     = 1'b1;
      expQ.push_back(r);
      busyUntil = acc + 1;
    end else begin
      for (int b = 0; b < n; b++) begin
        image[(a + b) % PBW] = data[8*b +: 8];
      end
      e0   = a / EB;
      e1   = (e0 + 1) % BC;
      span = ((a % EB) + n) > EB;
      r = blankRec(acc + 1); r.rdValid = 1'b1; r.rdIndex = e0; r.busy = 1'b1;
      expQ.push_back(r);
      r = blankRec(acc + 2); r.busy = 1'b1;
      expQ.push_back(r);
      r = blankRec(acc + 3); r.wrValid = 1'b1; r.wrIndex = e0;
      r.wrData = int'(modelElem(e0)); r.busy = 1'b1;
      expQ.push_back(r);
      busyUntil = acc + 3;
      if (span) begin
        r = blankRec(acc + 4); r.rdValid = 1'b1; r.rdIndex = e1; r.busy = 1'b1;
        expQ.push_back(r);
        r = blankRec(acc + 5); r.busy = 1'b1;
        expQ.push_back(r);
        r = blankRec(acc + 6); r.wrValid = 1'b1; r.wrIndex = e1;
        r.wrData = int'(modelElem(e1)); r.busy = 1'b1;
        expQ.push_back(r);
        busyUntil = acc + 6;
      end
    end
    @(posedge clk);
    #1;
    ReqValid = 1'b0;
  endtask

  // Hold reset for n clock edges. Anything still scheduled is dropped; every
  // cycle after a reset edge must show all-zero outputs.
  task automatic doReset(input int n);
    int k;
    expRecT r;
    k        = cycleNow;
    sync_rst = 1'b1;
    ReqValid = 1'b0;
    while (expQ.size() > 0 && expQ[$].cyc > k) begin
      void'(expQ.pop_back());
    end
    for (int i = 1; i <= n; i++) begin
      r = blankRec(k + i);
      r.fullCheck = 1'b1;
      r.reqReady  = (i == n);
      expQ.push_back(r);
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    sync_rst  = 1'b0;
    busyUntil = k + n - 1;
  endtask

  initial begin
    expRecT r;
    logic [15:0] rAddr;
    logic [15:0] rData;
    logic [3:0]  rOpc;
    int          pick;

    sync_rst      = 1'b1;
    ReqValid      = 1'b0;
    MinorOpcodeIn = '0;
    DataAddrIn    = '0;
    DataIn        = '0;
    pokeEn        = 1'b0;
    pokeIdx       = '0;
    pokeVal       = '0;

    @(posedge clk);
    #1;
    r = blankRec(cycleNow);
    r.fullCheck = 1'b1;
    expQ.push_back(r);
    checkEnable = 1'b1;
    doReset(3);

    for (int e = 0; e < BC; e++) begin
      setElement(e, 16'($urandom));
    end

    // Byte store into the upper lane of element 1.
    setElement(1, 16'h1234);
    applyStimulus(16'h0003, 4'd0, 16'h00AB);
    waitIdle();
    checkOutput("case1 ram elem1", ram[1], 16'hAB34);
    checkOutput("case1 model elem1", modelElem(1), 16'hAB34);

    // Aligned word: one RMW, busy for exactly three cycles.
    setElement(2, 16'h0000);
    busyCount = 0;
    applyStimulus(16'h0004, 4'd1, 16'hBEEF);
    waitIdle();
    checkOutput("case2 ram elem2", ram[2], 16'hBEEF);
    checkOutput("case2 busy cycles", busyCount, 3);

    // Misaligned word spanning elements 2 and 3.
    setElement(2, 16'h1111);
    setElement(3, 16'h2222);
    applyStimulus(16'h0005, 4'd1, 16'hBEEF);
    waitIdle();
    checkOutput("case3 ram elem2", ram[2], 16'hEF11);
    checkOutput("case3 ram elem3", ram[3], 16'h22BE);
    checkOutput("case3 model elem3", modelElem(3), 16'h22BE);

    // Word wrapping from the last element onto element 0.
    setElement(7, 16'h7777);
    setElement(0, 16'h0000);
    applyStimulus(16'h000F, 4'd1, 16'hBEEF);
    waitIdle();
    checkOutput("case4 ram elem7", ram[7], 16'hEF77);
    checkOutput("case4 ram elem0", ram[0], 16'h00BE);
    checkOutput("case4 model elem0", modelElem(0), 16'h00BE);

    // Double store is wider than an element: one error pulse, no RAM traffic.
    errCount    = 0;
    strobeCount = 0;
    applyStimulus(16'($urandom), 4'd2, 16'h5555);
    waitIdle();
    checkOutput("case5 error cycles", errCount, 1);
    checkOutput("case5 strobes", strobeCount, 0);

    // Reset during RD1 of a spanning store: WR0 landed, WR1 abandoned.
    setElement(2, 16'h1111);
    setElement(3, 16'h2222);
    setElement(4, 16'h0000);
    applyStimulus(16'h0005, 4'd1, 16'hBEEF);
    while (cycleNow < lastAcc + 4) begin
      @(posedge clk);
      #1;
    end
    doReset(2);
    restoreElement(3);
    checkOutput("case6 ram elem2", ram[2], 16'hEF11);
    checkOutput("case6 ram elem3", ram[3], 16'h2222);
    checkOutput("case6 model elem3", modelElem(3), 16'h2222);

    // Two back-to-back byte stores into element 4.
    acceptLog.delete();
    applyStimulus(16'h0008, 4'd0, 16'h005A);
    applyStimulus(16'h0009, 4'd0, 16'h00C3);
    waitIdle();
    checkOutput("case6 accept count", acceptLog.size(), 2);
    checkOutput("case6 accept spacing",
                (acceptLog.size() >= 2) ? (acceptLog[1] - acceptLog[0]) : -1, 4);
    checkOutput("case6 ram elem4", ram[4], 16'hC35A);
    checkOutput("case6 model elem4", modelElem(4), 16'hC35A);

    // Random stores, mostly byte/word with an occasional oversize one.
    for (int i = 0; i < 60; i++) begin
      rAddr = 16'($urandom);
      rData = 16'($urandom);
      pick  = $urandom_range(0, 9);
      rOpc  = 4'($urandom);
      if (pick < 4) begin
        rOpc[1:0] = 2'd0;
      end else if (pick < 8) begin
        rOpc[1:0] = 2'd1;
      end else if (pick == 8) begin
        rOpc[1:0] = 2'd2;
      end else begin
        rOpc[1:0] = 2'd3;
      end
      applyStimulus(rAddr, rOpc, rData);
    end
    waitIdle();

    for (int e = 0; e < BC; e++) begin
      checkOutput($sformatf("final elem%0d", e), ram[e], modelElem(e));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/io_store_rmw_aligner.md
Name: io_store_rmw_aligner

Overview:
- Sequential successor to the combinational IO store aligner.
- Accepts byte/word/double/quad stores at any byte address inside an IO port buffer of BUFFERCOUNT elements.
- Element writes are whole-element only, so the block performs read-modify-write through a single-ported element buffer.
- Supports misaligned stores that span two adjacent elements, including wrap-around from the last element to element 0.
- Sits between the IO store issue path and the port buffer RAM.

Parameters:
- DATABITWIDTH, 16, element/data width in bits; legal values 8, 16, 32, 64.
- PORTBYTEWIDTH, 16, port buffer size in bytes; power of 2, at least DATABITWIDTH/8.
- ELEMENTBYTES, DATABITWIDTH/8, bytes per element (derived).
- BUFFERCOUNT, max(1, PORTBYTEWIDTH*8/DATABITWIDTH), element count (derived).
- BUFFERINDEXBITWIDTH, max(1, clog2(BUFFERCOUNT)), element index width (derived).

Ports:
- clk  in  1  clock
- sync_rst  in  1  synchronous active-high reset
- ReqValid  in  1  store request valid
- ReqReady  out  1  request accepted when ReqValid and ReqReady are both high
- MinorOpcodeIn  in  4  bits[1:0] give the size: 0 byte, 1 word, 2 double, 3 quad; bits[3:2] ignored
- DataAddrIn  in  DATABITWIDTH  byte address; only bits [clog2(PORTBYTEWIDTH)-1:0] are used
- DataIn  in  DATABITWIDTH  store data, least-significant byte first
- RdValid  out  1  element read strobe
- RdIndex  out  BUFFERINDEXBITWIDTH  element read index
- RdData  in  DATABITWIDTH  read data, valid the cycle after RdValid
- WrValid  out  1  element write strobe (full element)
- WrIndex  out  BUFFERINDEXBITWIDTH  element write index
- WrData  out  DATABITWIDTH  merged element data
- Busy  out  1  high in every state except IDLE
- ErrorOut  out  1  one-cycle pulse for an unsupported size

Behaviour:
- Reset: state goes to IDLE; RdValid, WrValid, ErrorOut, Busy, RdIndex, WrIndex and WrData are all 0. ReqReady is 0 while sync_rst is high.
- ReqReady = (state == IDLE) && !sync_rst. On accept, the block registers size N = 1<<MinorOpcodeIn[1:0] bytes, A = DataAddrIn mod PORTBYTEWIDTH, and DataIn.
- Byte b of the store (0 ≤ b < N) targets byte p = (A+b) mod PORTBYTEWIDTH, element p / ELEMENTBYTES, lane p mod ELEMENTBYTES. Ordering is little-endian.
- E0 = A / ELEMENTBYTES. Span = ((A mod ELEMENTBYTES) + N > ELEMENTBYTES). When Span is true, E1 = (E0+1) mod BUFFERCOUNT.
- Error: if N > ELEMENTBYTES, the block goes to ERR. ERR lasts one cycle with ErrorOut=1 and no RdValid or WrValid, then returns to IDLE.
- States: IDLE -> RD0 -> MG0 -> WR0 -> (Span ? RD1 -> MG1 -> WR1 ->) IDLE; also IDLE -> ERR -> IDLE.
  - RD0 / RD1: RdValid=1, RdIndex = E0 / E1.
  - MG0 / MG1: register the merged element. Targeted lanes come from the matching DataIn bytes; all other lanes come from RdData.
  - WR0 / WR1: WrValid=1, WrIndex = E0 / E1, WrData = the merged register.
- Latency from the accept edge: WrValid in cycle 3 for a single-element store; WR1 in cycle 6 for a spanning store. ReqReady returns the cycle after the final WR or ERR, so back-to-back requests have no extra bubble.
- RdValid and WrValid are never high in the same cycle.
- When BUFFERCOUNT=1, a span wraps onto element 0. The same element is then read and written twice, and the second RMW sees the first write's result.
- Reset mid-operation: the block is in IDLE the next cycle with all strobes low. A partially completed spanning store, with WR0 done and WR1 pending, is abandoned; no WR1 is issued.
- DATABITWIDTH=8: every legal store is a single byte, Span is always false, and all non-byte sizes error.

Test Plan:
All cases use DATABITWIDTH=16, PORTBYTEWIDTH=16 (ELEMENTBYTES=2, BUFFERCOUNT=8).
1. Byte store, A=0x3, DataIn=0x00AB, elem1=0x1234 -> RdIndex=1, then WrValid at accept+3 with WrIndex=1, WrData=0xAB34; exactly one write.
2. Aligned word, A=0x4, DataIn=0xBEEF, elem2=0x0000 -> single RMW: WrIndex=2, WrData=0xBEEF; Busy high for 3 cycles.
3. Misaligned word, A=0x5, DataIn=0xBEEF, elem2=0x1111, elem3=0x2222 -> writes elem2=0xEF11 at accept+3 and elem3=0x22BE at accept+6.
4. Wrap, A=0xF, DataIn=0xBEEF, elem7=0x7777, elem0=0x0000 -> writes elem7=0xEF77, then elem0=0x00BE.
5. Double store (size 2), any address -> ErrorOut=1 for exactly 1 cycle; no RdValid or WrValid; ReqReady=1 the following cycle.
6. sync_rst asserted during RD1 of case 3 -> next cycle all outputs 0 and no WR1. Then two back-to-back byte stores complete with consecutive accepts 4 cycles apart.
